// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned         DIGIT_W   = 4;
   localparam logic [DIGIT_W-1:0]  BCD_MAX   = 4'd9;
   localparam logic [DIGIT_W:0]    BCD_RADIX = 5'd10;

   function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
      return d > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add with decimal correction; raw binary sum is exposed for the
// downstream tens/ones splitter.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] a_d,
   input  logic [DIGIT_W-1:0] b_d,
   input  logic               c_in,
   output logic [DIGIT_W:0]   raw,
   output logic [DIGIT_W-1:0] digit,
   output logic               c_out,
   output logic               bad
);

   // Operands are extended to 5 bits so even two invalid digits (15+15+1) fit.
   assign raw   = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, c_in};
   assign c_out = raw > {1'b0, BCD_MAX};
   assign digit = c_out ? DIGIT_W'(raw - BCD_RADIX) : raw[DIGIT_W-1:0];
   assign bad   = digit_bad(a_d) | digit_bad(b_d);

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, least-significant digit first, with a
// start/done handshake and a single shared digit adder.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [DIGIT_W*DIGITS-1:0]     a,
   input  logic [DIGIT_W*DIGITS-1:0]     b,
   input  logic                          cin,
   output logic                          busy,
   output logic                          done,
   output logic [DIGIT_W*DIGITS-1:0]     sum,
   output logic                          cout,
   output logic                          invalid,
   output logic [DIGIT_W:0]              digit_raw,
   output logic [$clog2(DIGITS):0]       digit_idx
);

   localparam int IW = $clog2(DIGITS) + 1;
   localparam int W  = DIGIT_W * DIGITS;

   state_t            state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [W-1:0]      opa_q, opa_d, opb_q, opb_d, sum_q, sum_d;
   logic              carry_q, carry_d, cout_q, cout_d, invalid_q, invalid_d;

   logic [DIGIT_W-1:0] cur_a, cur_b, dig;
   logic [DIGIT_W:0]   raw;
   logic               c_out, bad, any_bad;

   assign cur_a = opa_q[int'(idx_q)*DIGIT_W +: DIGIT_W];
   assign cur_b = opb_q[int'(idx_q)*DIGIT_W +: DIGIT_W];

   bcd_digit_add u_digit (
      .a_d   (cur_a),
      .b_d   (cur_b),
      .c_in  (carry_q),
      .raw   (raw),
      .digit (dig),
      .c_out (c_out),
      .bad   (bad)
   );

   always_comb begin
      any_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         any_bad = any_bad | digit_bad(a[i*DIGIT_W +: DIGIT_W])
                           | digit_bad(b[i*DIGIT_W +: DIGIT_W]);
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      carry_d   = carry_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      invalid_d = invalid_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = ADD;
               idx_d     = '0;
               opa_d     = a;
               opb_d     = b;
               carry_d   = cin;
               sum_d     = '0;
               cout_d    = 1'b0;
               invalid_d = any_bad;
            end
         end
         ADD: begin
            sum_d[int'(idx_q)*DIGIT_W +: DIGIT_W] = dig;
            carry_d   = c_out;
            invalid_d = invalid_q | bad;
            if (idx_q == IW'(DIGITS - 1)) begin
               cout_d  = c_out;
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operand registers are left out of reset; they are always reloaded on accept.
   always_ff @(posedge clk) begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
         invalid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
         invalid_q <= invalid_d;
      end
   end

   assign busy      = (state_q == ADD);
   assign done      = (state_q == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign invalid   = invalid_q;
   assign digit_raw = busy ? raw : '0;
   assign digit_idx = busy ? idx_q : '0;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a decimal reference model.
module tb_bcd_serial_adder;

   localparam int D = 2;
   localparam int W = 4 * D;

   logic           clk = 1'b0;
   logic           reset, start, cin;
   logic [W-1:0]   a, b;
   logic           busy, done, cout, invalid;
   logic [W-1:0]   sum;
   logic [4:0]     digit_raw;
   logic [$clog2(D):0] digit_idx;

   int n_checks = 0;
   int n_pass   = 0;

   bcd_serial_adder #(.DIGITS(D)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
      .invalid   (invalid),
      .digit_raw (digit_raw),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: valid operands use plain decimal arithmetic; the per-digit rule
   // supplies raw sums and covers operands with non-decimal digits.
   task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        output int raws[D], output logic [W-1:0] es,
                        output logic ec, output logic einv);
      int c, t, av, bv, sv, p;
      logic [W-1:0] loop_sum;
      c = tc; einv = 1'b0; av = 0; bv = 0; p = 1; loop_sum = '0;
      for (int d = 0; d < D; d++) begin
         int ad, bd;
         ad = int'(ta[d*4 +: 4]);
         bd = int'(tb_[d*4 +: 4]);
         if (ad > 9 || bd > 9) einv = 1'b1;
         av += ad * p; bv += bd * p; p *= 10;
         t = ad + bd + c;
         raws[d] = t;
         if (t > 9) begin t -= 10; c = 1; end else c = 0;
         loop_sum[d*4 +: 4] = 4'(t % 16);
      end
      if (einv) begin
         es = loop_sum;
         ec = logic'(c);
      end else begin
         sv = av + bv + int'(tc);
         ec = (sv >= p);
         sv = sv % p;
         for (int d = 0; d < D; d++) begin
            es[d*4 +: 4] = 4'(sv % 10);
            sv /= 10;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                         input bit hold_start);
      int raws[D];
      logic [W-1:0] es;
      logic ec, einv;
      model(ta, tb_, tc, raws, es, ec, einv);
      a = ta; b = tb_; cin = tc; start = 1'b1;
      tick();
      if (!hold_start) start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      for (int d = 0; d < D; d++) begin
         check($sformatf("busy[%0d]", d), 32'(busy), 32'd1);
         check($sformatf("idx[%0d]", d), 32'(digit_idx), 32'(d));
         check($sformatf("raw[%0d] %h+%h", d, ta, tb_), 32'(digit_raw), 32'(raws[d]));
         if (d < D - 1) tick();
      end
      tick();
      check("done_pulse", 32'(done), 32'd1);
      check("busy_in_done", 32'(busy), 32'd0);
      check($sformatf("sum %h+%h+%0d", ta, tb_, tc), 32'(sum), 32'(es));
      check($sformatf("cout %h+%h+%0d", ta, tb_, tc), 32'(cout), 32'(ec));
      check("invalid", 32'(invalid), 32'(einv));
      tick();
      check("done_cleared", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("sum_hold", 32'(sum), 32'(es));
      check("cout_hold", 32'(cout), 32'(ec));
      check("invalid_hold", 32'(invalid), 32'(einv));
      check("raw_idle", 32'(digit_raw), 32'd0);
      check("idx_idle", 32'(digit_idx), 32'd0);
   endtask

   function automatic logic [W-1:0] rand_operand();
      logic [W-1:0] v;
      for (int d = 0; d < D; d++) begin
         if ($urandom_range(0, 7) == 0) v[d*4 +: 4] = 4'($urandom_range(0, 15));
         else                           v[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      return v;
   endfunction

   initial begin
      reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick(); tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_invalid", 32'(invalid), 32'd0);
      check("rst_raw", 32'(digit_raw), 32'd0);
      check("rst_idx", 32'(digit_idx), 32'd0);
      reset = 1'b0;
      tick();

      run_op(8'h47, 8'h38, 1'b0, 1'b0);
      run_op(8'h99, 8'h99, 1'b1, 1'b0);
      run_op(8'hA3, 8'h01, 1'b0, 1'b0);

      // start held across an operation: second accept lands in the first IDLE cycle
      run_op(8'h12, 8'h34, 1'b0, 1'b1);
      run_op(8'h56, 8'h78, 1'b1, 1'b1);
      start = 1'b0;
      tick();

      // reset during the second ADD cycle
      a = 8'hA3; b = 8'h09; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_sum", 32'(sum), 32'd0);
      check("mid_rst_cout", 32'(cout), 32'd0);
      check("mid_rst_invalid", 32'(invalid), 32'd0);
      check("mid_rst_raw", 32'(digit_raw), 32'd0);
      check("mid_rst_idx", 32'(digit_idx), 32'd0);
      tick();
      check("mid_rst_no_done", 32'(done), 32'd0);
      run_op(8'h25, 8'h17, 1'b0, 1'b0);

      run_op(8'h00, 8'h00, 1'b0, 1'b0);
      run_op(8'h50, 8'h50, 1'b0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_op(rand_operand(), rand_operand(), 1'($urandom), 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
